spi_flash_target: RTL and testbench

SPI mode-0 target that emulates the read side of a serial NOR flash, so the SoC's SPI flash master can be exercised in simulation and on a second board without a physical flash. It oversamples the master's SCK/CS/SDI in the system clock domain and decodes READ (0x03) and JEDEC-ID (0x9F). Read data comes from an external byte-wide memory port (ROM/BRAM image). The target drives SDO back to the master.

---
 rtl/spi_flash_target.sv | 227 ++++++++++++++++++++++
 tb/tb_spi_flash_target.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_target.sv
// Purpose : SPI mode-0 target emulating the read side of a serial NOR flash (READ 0x03, JEDEC-ID 0x9F).
// Latency : SCK/CS pin edge to internal detect 2-3 clk_i; SDO 1 clk_i after fall detect; mem_rdata_i 1 clk_i after mem_req_o.
// Backpressure: none; the master paces everything through SCK, so memory must answer in exactly one cycle.
// Optional: define SPI_FLASH_TARGET_FASTREAD_EN to accept FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_target #(
    parameter int          ADDR_WIDTH = 24,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sck_i,
    input  logic                  cs_i,
    input  logic                  sdi_i,
    output logic                  sdo_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [7:0]            mem_rdata_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
        S_DUMMY,
`endif
        S_DATA,
        S_JEDEC,
        S_IGNORE
    } state_t;

    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic sdi_s1, sdi_s2;

    state_t                state;
    logic [4:0]            bit_cnt;
    logic [6:0]            cmd_shift;
    logic [ADDR_WIDTH-2:0] addr_shift;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            tx_shift;
    logic                  load_pending;
    logic [1:0]            jed_idx;
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
    logic                  fast;
`endif

    logic                  sck_rise, sck_fall, cs_rise, cs_fall;
    logic [7:0]            cmd_byte;
    logic [ADDR_WIDTH-1:0] addr_shifted;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic                  last_addr_bit, last_data_bit;

    // Two-flop synchronizers plus a delayed copy for edge detection; idle levels on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sck_s1 <= 1'b0; sck_s2 <= 1'b0; sck_d <= 1'b0;
            cs_s1  <= 1'b1; cs_s2  <= 1'b1; cs_d  <= 1'b1;
            sdi_s1 <= 1'b0; sdi_s2 <= 1'b0;
        end else begin
            sck_s1 <= sck_i;  sck_s2 <= sck_s1; sck_d <= sck_s2;
            cs_s1  <= cs_i;   cs_s2  <= cs_s1;  cs_d  <= cs_s2;
            sdi_s1 <= sdi_i;  sdi_s2 <= sdi_s1;
        end
    end

    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign cs_fall  = ~cs_s2 & cs_d;
    assign cs_rise  = cs_s2 & ~cs_d;

    // Shift registers seen with the bit arriving this cycle appended.
    assign cmd_byte     = {cmd_shift, sdi_s2};
    assign addr_shifted = {addr_shift, sdi_s2};

    // The memory strobe fires in the very cycle the last address/data bit is sampled,
    // so the byte is back in time for the following SCK fall.
    assign last_addr_bit = (state == S_ADDR) && sck_rise && (bit_cnt == 5'd23) && !cs_rise;
    assign last_data_bit = (state == S_DATA) && sck_rise && (bit_cnt == 5'd7) && !cs_rise;
    assign addr_next     = last_addr_bit ? addr_shifted
                                         : addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    assign mem_req_o     = last_addr_bit | last_data_bit;
    assign mem_addr_o    = mem_req_o ? addr_next : '0;

    // Transaction FSM: command decode, address collection, byte streaming; CS rise aborts anything.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            cmd_shift    <= '0;
            addr_shift   <= '0;
            addr         <= '0;
            tx_shift     <= '0;
            load_pending <= 1'b0;
            jed_idx      <= '0;
            sdo_o        <= 1'b0;
            busy_o       <= 1'b0;
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
            fast         <= 1'b0;
`endif
        end else begin
            load_pending <= mem_req_o;
            if (cs_rise) begin
                state   <= S_IDLE;
                busy_o  <= 1'b0;
                sdo_o   <= 1'b0;
                bit_cnt <= '0;
                jed_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (cs_fall) begin
                            state   <= S_CMD;
                            busy_o  <= 1'b1;
                            bit_cnt <= '0;
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
                            fast    <= 1'b0;
`endif
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            cmd_shift <= cmd_byte[6:0];
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (cmd_byte)
                                    8'h03: state <= S_ADDR;
                                    8'h9F: begin
                                        state    <= S_JEDEC;
                                        tx_shift <= JEDEC_ID[23:16];
                                        jed_idx  <= 2'd1;
                                    end
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
                                    8'h0B: begin
                                        state <= S_ADDR;
                                        fast  <= 1'b1;
                                    end
`endif
                                    default: state <= S_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        if (sck_rise) begin
                            addr_shift <= addr_shifted[ADDR_WIDTH-2:0];
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                addr    <= addr_next;
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
                                state   <= fast ? S_DUMMY : S_DATA;
`else
                                state   <= S_DATA;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
                    S_DUMMY: begin
                        // tx_shift already holds the first byte; just count 8 clocks with SDO low.
                        if (sck_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                state   <= S_DATA;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
`endif
                    S_DATA: begin
                        if (sck_fall) begin
                            sdo_o    <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (sck_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                addr    <= addr_next;
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_JEDEC: begin
                        if (sck_fall) begin
                            sdo_o    <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                        end
                        if (sck_rise) begin
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (jed_idx)
                                    2'd1: begin
                                        tx_shift <= JEDEC_ID[15:8];
                                        jed_idx  <= 2'd2;
                                    end
                                    2'd2: begin
                                        tx_shift <= JEDEC_ID[7:0];
                                        jed_idx  <= 2'd3;
                                    end
                                    default: tx_shift <= 8'h00;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    S_IGNORE: begin
                        sdo_o <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
            // Memory data lands one cycle after the strobe, well before the next SCK fall.
            if (load_pending) begin
                tx_shift <= mem_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_target.sv
// Randomized SPI master driving spi_flash_target against a byte-stream reference model.
// Expected SDO bytes and memory addresses are queued at stimulus time; monitors pop and compare.
// Runs every scenario at SCK = clk/4 and clk/10.
`timescale 1ns/1ps
module tb_spi_flash_target;

    localparam int          AW  = 14;
    localparam logic [23:0] JID = 24'hEF4018;
    localparam int          CP  = 10;
`ifdef SPI_FLASH_TARGET_FASTREAD_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sck = 1'b0;
    logic          cs = 1'b1;
    logic          sdi = 1'b0;
    logic          sdo, mem_req, busy;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;

    int checks = 0;
    int failures = 0;
    int half = 2;

    logic [7:0]    exp_q[$];
    logic [7:0]    rx_q[$];
    logic [AW-1:0] addr_q[$];

    always #(CP/2) clk = ~clk;

    spi_flash_target #(.ADDR_WIDTH(AW), .JEDEC_ID(JID)) dut (
        .clk_i(clk), .rst_ni(rst_n), .sck_i(sck), .cs_i(cs), .sdi_i(sdi),
        .sdo_o(sdo), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    // Memory image: low bits of the address folded with a constant, upper address bits mixed in.
    function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5 ^ {2'b00, a[13:8]};
    endfunction

    // One-cycle read latency memory.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= mem_f(mem_addr);
    end

    // Memory request monitor.
    always @(negedge clk) begin
        if (mem_req) begin
            checks++;
            if (addr_q.size() == 0) begin
                failures++;
                $display("FAIL mem_req_unexpected addr=%h", mem_addr);
            end else begin
                logic [AW-1:0] ea;
                ea = addr_q.pop_front();
                if (mem_addr !== ea) begin
                    failures++;
                    $display("FAIL mem_addr got=%h exp=%h", mem_addr, ea);
                end
            end
        end
    end

    // SDO byte monitor.
    always @(posedge clk) begin
        while (rx_q.size() > 0) begin
            logic [7:0] r, e;
            r = rx_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sdo_byte_unexpected got=%h", r);
            end else begin
                e = exp_q.pop_front();
                if (r !== e) begin
                    failures++;
                    $display("FAIL sdo_byte got=%h exp=%h half=%0d", r, e, half);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    // Clock nbits through the target; returns SDO as bytes (a trailing partial byte left-aligned).
    task automatic xfer(input logic [7:0] tx[$], input int nbits, input bit end_cs,
                        output logic [7:0] rx[$]);
        logic       r;
        logic [7:0] acc;
        rx = {};
        acc = 8'h00;
        @(posedge clk); #3;
        cs = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        for (int i = 0; i < nbits; i++) begin
            if (i / 8 < tx.size()) sdi = tx[i/8][7 - (i % 8)];
            else sdi = 1'($urandom_range(0, 1));
            #(half * CP);
            sck = 1'b1;
            #(half * CP);
            r = sdo;          // latest the master could sample before its next fall
            sck = 1'b0;
            if (i == 0) chk("busy_active", {31'b0, busy}, 32'd1);
            acc = {acc[6:0], r};
            if (i % 8 == 7) begin
                rx.push_back(acc);
                acc = 8'h00;
            end
        end
        if (nbits % 8 != 0) rx.push_back(acc << (8 - nbits % 8));
        if (end_cs) begin
            sdi = 1'b0;
            #(half * CP);
            cs = 1'b1;
            repeat (6) @(posedge clk);
            #3;
            chk("busy_idle", {31'b0, busy}, 32'd0);
        end
    endtask

    // Reference model: build expected SDO stream and memory requests, then run the transaction.
    // abort_bits < 0 means a complete transaction of header + nbytes.
    task automatic run(input logic [7:0] cmd, input logic [23:0] addr, input int nbytes,
                       input int abort_bits);
        logic [7:0]    tx[$];
        logic [7:0]    rx[$];
        logic [AW-1:0] base;
        logic [7:0]    eb;
        bit            is_read, is_jedec;
        int            hdr, nbits, nb, rem, nreq, d;
        tx = {};
        tx.push_back(cmd); tx.push_back(addr[23:16]); tx.push_back(addr[15:8]); tx.push_back(addr[7:0]);
        is_read  = (cmd == 8'h03) || (FAST && cmd == 8'h0B);
        is_jedec = (cmd == 8'h9F);
        hdr = is_read ? ((cmd == 8'h0B) ? 5 : 4) : 1;
        nbits = (abort_bits >= 0) ? abort_bits : (hdr + nbytes) * 8;
        base = addr[AW-1:0];
        nb = (nbits + 7) / 8;
        rem = nbits % 8;
        for (int j = 0; j < nb; j++) begin
            d = j - hdr;
            eb = 8'h00;
            if (d >= 0 && is_read) eb = mem_f(base + AW'(d));
            if (d >= 0 && is_jedec) begin
                if (d == 0) eb = JID[23:16];
                else if (d == 1) eb = JID[15:8];
                else if (d == 2) eb = JID[7:0];
            end
            if (j == nb - 1 && rem != 0) eb = eb & (8'hFF << (8 - rem));
            exp_q.push_back(eb);
        end
        if (is_read && nbits >= 32) begin
            nreq = 1 + ((nbits > hdr * 8) ? (nbits - hdr * 8) / 8 : 0);
            for (int k = 0; k < nreq; k++) addr_q.push_back(base + AW'(k));
        end
        xfer(tx, nbits, 1'b1, rx);
        foreach (rx[k]) rx_q.push_back(rx[k]);
    endtask

    // Reset in the middle of a READ data byte: outputs clear at once, then JEDEC works.
    task automatic reset_mid_data();
        logic [7:0] tx[$];
        logic [7:0] rx[$];
        logic [7:0] b;
        tx = {};
        tx.push_back(8'h03); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h11);
        addr_q.push_back(AW'(14'h0011));
        addr_q.push_back(AW'(14'h0012));
        xfer(tx, 32 + 8 + 3, 1'b0, rx);
        repeat (4) @(posedge clk);
        #3;
        b = mem_f(AW'(14'h0012));
        chk("sdo_before_reset", {31'b0, sdo}, {31'b0, b[4]});
        chk("busy_before_reset", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sdo", {31'b0, sdo}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        cs = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run(8'h9F, 24'h000000, 3, -1);
    endtask

    initial begin
        #(800_000);
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #3;
        chk("reset_sdo", {31'b0, sdo}, 32'd0);
        chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset_mem_addr", {18'b0, mem_addr}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int s = 0; s < 2; s++) begin
            half = (s == 0) ? 2 : 5;
            run(8'h03, 24'h000010, 4, -1);     // B5 B4 B7 B6
            run(8'h03, 24'h003FFF, 2, -1);     // wraps to 0
            run(8'h03, 24'h000000, 0, 21);     // CS abort after 13 address bits
            run(8'h03, 24'h000000, 1, -1);     // mem[0] right after abort
            run(8'h05, 24'h000000, 2, -1);     // unknown command
            run(8'h0B, 24'h000010, 1, -1);     // fast read or ignored
            run(8'h9F, 24'h000000, 5, -1);     // ID then zeros
            run(8'h03, 24'hFFC123, 2, -1);     // upper address bits ignored
            reset_mid_data();
            for (int n = 0; n < 8; n++) begin
                logic [7:0]  c;
                logic [23:0] a;
                int          nbyt, ab, full;
                case ($urandom_range(0, 4))
                    0, 1:    c = 8'h03;
                    2:       c = 8'h9F;
                    3:       c = 8'h0B;
                    default: c = 8'($urandom_range(0, 255));
                endcase
                a = 24'($urandom);
                nbyt = $urandom_range(0, 3);
                full = ((c == 8'h0B && FAST) ? 5 : 4) * 8 + nbyt * 8;
                ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, full) : -1;
                run(c, a, nbyt, ab);
            end
        end

        repeat (10) @(posedge clk);
        #3;
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("addr_q_drained", addr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
